rgb565_gray_pack_ise: RTL and testbench
=======================================

// Module: rgb565_gray_pack_ise
// PURPOSE
//  Multi-cycle OpenRISC custom instruction; downstream packing stage of the RGB565->grayscale path.
//  Converts four RGB565 camera pixels (two per operand) into four 8-bit gray pixels packed in one word.
//  The CPU then stores each result word straight into the grayscale framebuffer: one CI + one store per 4 px.
//  Sits on the shared CI bus: result is OR-ed with other ISEs, so it is 0 whenever done is low.
// PARAMETERS
//  customInstructionId  8'd0  ciN value this block answers to
// PORTS
//  clock       in   1   system clock; all state on rising edge
//  reset       in   1   synchronous, active-high reset
//  ciStart     in   1   CPU issues a custom instruction this cycle
//  ciCke       in   1   CI clock enable; low = hold all state (stall)
//  ciN         in   8   custom instruction id; block responds only if == customInstructionId
//  ciValueA    in   32  pixels 0 ([15:0]) and 1 ([31:16]), RGB565
//  ciValueB    in   32  pixels 2 ([15:0]) and 3 ([31:16]), RGB565
//  ciDone      out  1   completion strobe, one cycle
//  ciResult    out  32  {gray3, gray2, gray1, gray0}; 0 when ciDone low
// BEHAVIOUR
//  Reset: state=IDLE, ciDone=0, ciResult=0, all pipeline regs 0. Applies mid-operation: op is dropped.
//  Accept: at an edge where state==IDLE & ciCke & ciStart & ciN==customInstructionId; latch A,B.
//  FSM (advances only on edges with ciCke=1; ciCke=0 freezes state and all regs, ciDone/ciResult held):
//   IDLE -> MUL on accept; else stay.
//   MUL  -> ADD: per pixel, expand to 8 bit: R8={R5,R5[4:2]}, G8={G6,G6[5:4]}, B8={B5,B5[4:2]};
//          register pR=54*R8, pG=183*G8, pB=19*B8 (16 bit each, no overflow).
//   ADD  -> DONE: per pixel s=pR+pG+pB (16 bit; max 65280, no overflow); gray=s[15:8]; pack into result reg.
//   DONE -> IDLE: ciDone=1 and ciResult=packed word during the DONE cycle only.
//  Latency: accept at edge k -> ciDone high in the cycle after edge k+2 (3 cycles with ciCke=1).
//  ciDone and ciResult are registered (state==DONE), never combinational from inputs.
//  ciStart in MUL/ADD/DONE (any ciN) ignored; no queueing. ciStart with other ciN never accepted.
//  Pixel order fixed: gray0->[7:0], gray1->[15:8], gray2->[23:16], gray3->[31:24].
//  Single-cycle ISEs sharing the bus are unaffected: outside DONE this block drives 0 on both outputs.
// TESTING
//  A=0xFFFF0000, B=0x001F07E0, ciN match -> after 3 cycles ciDone=1 one cycle, ciResult=0x12B6FF00.
//  A=0xF800F800, B=0xFFFF0000 -> ciResult=0xFF003535; ciResult=0 in every other cycle.
//  ciStart with ciN!=customInstructionId -> ciDone stays 0, ciResult stays 0, state IDLE.
//  Accept, then hold ciCke=0 for 5 cycles in ADD -> ciDone appears 5 cycles later, value unchanged.
//  Accept, assert reset in MUL -> next cycle IDLE, no ciDone; fresh accept afterwards completes normally.
//  Second ciStart (matching id) issued in MUL -> ignored; exactly one ciDone, result of first operands.

Source files
------------

// File: rtl/rgb565_gray_pack_ise.sv
// rgb565_gray_pack_ise: multi-cycle custom instruction that converts four
// RGB565 pixels (two per operand) into four 8-bit gray pixels packed in one
// 32-bit word. Three working states after accept: MUL, ADD, DONE.
// Outputs are forced to zero outside DONE so the block can share an OR-ed
// result bus with other instruction extensions.
module rgb565_gray_pack_ise #(
  parameter logic [7:0] customInstructionId = 8'd0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ciStart,
  input  logic        ciCke,
  input  logic [7:0]  ciN,
  input  logic [31:0] ciValueA,
  input  logic [31:0] ciValueB,
  output logic        ciDone,
  output logic [31:0] ciResult
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    ADD  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      stateQ, stateD;
  logic [63:0] pixQ, pixD;
  logic [15:0] pRQ [4];
  logic [15:0] pRD [4];
  logic [15:0] pGQ [4];
  logic [15:0] pGD [4];
  logic [15:0] pBQ [4];
  logic [15:0] pBD [4];
  logic [31:0] resultQ, resultD;

  logic        accept;
  logic [7:0]  r8 [4];
  logic [7:0]  g8 [4];
  logic [7:0]  b8 [4];
  logic [15:0] sum [4];

  assign accept = (stateQ == IDLE) && ciStart && (ciN == customInstructionId);

  // Next-state logic: a fixed walk through MUL, ADD and DONE once accepted
  always_comb begin
    stateD = stateQ;
    case (stateQ)
      IDLE:    if (accept) stateD = MUL;
      MUL:     stateD = ADD;
      ADD:     stateD = DONE;
      DONE:    stateD = IDLE;
      default: stateD = IDLE;
    endcase
  end

  // Channel expansion to 8 bits by replicating the top bits into the gap
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      r8[i] = {pixQ[16*i+11 +: 5], pixQ[16*i+13 +: 3]};
      g8[i] = {pixQ[16*i+5 +: 6], pixQ[16*i+9 +: 2]};
      b8[i] = {pixQ[16*i +: 5], pixQ[16*i+2 +: 3]};
    end
  end

  // Datapath next values: latch operands, weight channels, then sum and pack
  always_comb begin
    pixD    = pixQ;
    resultD = resultQ;
    for (int i = 0; i < 4; i++) begin
      pRD[i] = pRQ[i];
      pGD[i] = pGQ[i];
      pBD[i] = pBQ[i];
      sum[i] = pRQ[i] + pGQ[i] + pBQ[i];
    end
    if (accept) begin
      pixD = {ciValueB, ciValueA};
    end
    if (stateQ == MUL) begin
      for (int i = 0; i < 4; i++) begin
        pRD[i] = {8'd0, r8[i]} * 16'd54;
        pGD[i] = {8'd0, g8[i]} * 16'd183;
        pBD[i] = {8'd0, b8[i]} * 16'd19;
      end
    end
    if (stateQ == ADD) begin
      for (int i = 0; i < 4; i++) begin
        resultD[8*i +: 8] = sum[i][15:8];
      end
    end
  end

  // State and pipeline registers; a low clock enable freezes everything
  always_ff @(posedge clock) begin
    if (reset) begin
      stateQ  <= IDLE;
      pixQ    <= '0;
      resultQ <= '0;
      for (int i = 0; i < 4; i++) begin
        pRQ[i] <= '0;
        pGQ[i] <= '0;
        pBQ[i] <= '0;
      end
    end else if (ciCke) begin
      stateQ  <= stateD;
      pixQ    <= pixD;
      resultQ <= resultD;
      for (int i = 0; i < 4; i++) begin
        pRQ[i] <= pRD[i];
        pGQ[i] <= pGD[i];
        pBQ[i] <= pBD[i];
      end
    end
  end

  // Bus outputs decoded from registered state only; zero outside DONE
  always_comb begin
    ciDone   = (stateQ == DONE);
    ciResult = (stateQ == DONE) ? resultQ : 32'd0;
  end

endmodule

// File: tb/tb_rgb565_gray_pack_ise.sv
// Testbench for rgb565_gray_pack_ise: directed scenarios plus randomized
// traffic, compared every cycle against a behavioural model of the
// instruction (luma arithmetic plus a countdown of enabled clock edges).
module tb_rgb565_gray_pack_ise;

  localparam logic [7:0] ID = 8'd0;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ciStart = 1'b0;
  logic        ciCke = 1'b1;
  logic [7:0]  ciN = 8'd0;
  logic [31:0] ciValueA = 32'd0;
  logic [31:0] ciValueB = 32'd0;
  logic        ciDone;
  logic [31:0] ciResult;

  int checks = 0;
  int passes = 0;
  int doneCount = 0;
  logic [31:0] lastResult = 32'd0;
  bit checkEn = 1'b0;

  int          phase = 0;
  logic [31:0] expWord = 32'd0;

  rgb565_gray_pack_ise #(.customInstructionId(ID)) dut (
    .clock   (clock),
    .reset   (reset),
    .ciStart (ciStart),
    .ciCke   (ciCke),
    .ciN     (ciN),
    .ciValueA(ciValueA),
    .ciValueB(ciValueB),
    .ciDone  (ciDone),
    .ciResult(ciResult)
  );

  always #5 clock = ~clock;

  // Reference luma of one RGB565 pixel using plain integer arithmetic
  function automatic int grayOf(input logic [15:0] pix);
    int r5, g6, b5, r8, g8, b8;
    r5 = int'(pix[15:11]);
    g6 = int'(pix[10:5]);
    b5 = int'(pix[4:0]);
    r8 = r5 * 8 + r5 / 4;
    g8 = g6 * 4 + g6 / 16;
    b8 = b5 * 8 + b5 / 4;
    return (54 * r8 + 183 * g8 + 19 * b8) / 256;
  endfunction

  function automatic logic [31:0] packGray(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] w;
    w[7:0]   = 8'(grayOf(a[15:0]));
    w[15:8]  = 8'(grayOf(a[31:16]));
    w[23:16] = 8'(grayOf(b[15:0]));
    w[31:24] = 8'(grayOf(b[31:16]));
    return w;
  endfunction

  // Model: phase counts enabled edges since accept; result shows at phase 3
  always @(posedge clock) begin
    if (reset) begin
      phase = 0;
    end else if (ciCke) begin
      if (phase == 0) begin
        if (ciStart && ciN == ID) begin
          phase   = 1;
          expWord = packGray(ciValueA, ciValueB);
        end
      end else if (phase == 3) begin
        phase = 0;
      end else begin
        phase = phase + 1;
      end
    end
  end

  // Per-cycle comparison against the model on the falling edge
  always @(negedge clock) begin
    if (checkEn) begin
      logic        eDone;
      logic [31:0] eRes;
      eDone = (phase == 3);
      eRes  = eDone ? expWord : 32'd0;
      checks = checks + 1;
      if (ciDone === eDone && ciResult === eRes) begin
        passes = passes + 1;
      end else begin
        $display("[TB] FAIL cycleCompare t=%0t done=%b result=%h expected done=%b result=%h",
                 $time, ciDone, ciResult, eDone, eRes);
      end
      if (ciDone === 1'b1) begin
        doneCount  = doneCount + 1;
        lastResult = ciResult;
      end
    end
  end

  task automatic applyStimulus(input logic rst, input logic start, input logic [7:0] n,
                               input logic [31:0] a, input logic [31:0] b, input logic cke);
    @(posedge clock);
    #1;
    reset    = rst;
    ciStart  = start;
    ciN      = n;
    ciValueA = a;
    ciValueB = b;
    ciCke    = cke;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) applyStimulus(1'b0, 1'b0, ID, 32'd0, 32'd0, 1'b1);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks = checks + 1;
    if (actual === expected) begin
      passes = passes + 1;
    end else begin
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  int doneBefore;

  initial begin
    // Reset state
    applyStimulus(1'b1, 1'b0, ID, 32'd0, 32'd0, 1'b1);
    applyStimulus(1'b1, 1'b0, ID, 32'd0, 32'd0, 1'b1);
    checkEn = 1'b1;
    checkOutput("resetDone", {31'd0, ciDone}, 32'd0);
    checkOutput("resetResult", ciResult, 32'd0);
    idle(2);

    // Known vector 1: white, pure green, pure blue, black
    doneBefore = doneCount;
    applyStimulus(1'b0, 1'b1, ID, 32'hFFFF0000, 32'h001F07E0, 1'b1);
    idle(5);
    checkOutput("vec1DoneCount", 32'(doneCount - doneBefore), 32'd1);
    checkOutput("vec1Result", lastResult, 32'h12B6FF00);

    // Known vector 2: pure red pair, black, white
    doneBefore = doneCount;
    applyStimulus(1'b0, 1'b1, ID, 32'hF800F800, 32'hFFFF0000, 1'b1);
    idle(5);
    checkOutput("vec2DoneCount", 32'(doneCount - doneBefore), 32'd1);
    checkOutput("vec2Result", lastResult, 32'hFF003535);

    // Foreign instruction id must never be accepted
    doneBefore = doneCount;
    applyStimulus(1'b0, 1'b1, 8'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    applyStimulus(1'b0, 1'b1, 8'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    idle(5);
    checkOutput("foreignIdNoDone", 32'(doneCount - doneBefore), 32'd0);

    // Clock-enable stall while in ADD
    doneBefore = doneCount;
    applyStimulus(1'b0, 1'b1, ID, 32'hFFFF0000, 32'h001F07E0, 1'b1);
    applyStimulus(1'b0, 1'b0, ID, 32'd0, 32'd0, 1'b1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, ID, 32'h12345678, 32'h9ABCDEF0, 1'b0);
    idle(5);
    checkOutput("stallDoneCount", 32'(doneCount - doneBefore), 32'd1);
    checkOutput("stallResult", lastResult, 32'h12B6FF00);

    // Reset while in MUL drops the operation; fresh accept completes
    doneBefore = doneCount;
    applyStimulus(1'b0, 1'b1, ID, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    applyStimulus(1'b1, 1'b0, ID, 32'd0, 32'd0, 1'b1);
    idle(5);
    checkOutput("resetDropsOp", 32'(doneCount - doneBefore), 32'd0);
    applyStimulus(1'b0, 1'b1, ID, 32'hF800F800, 32'hFFFF0000, 1'b1);
    idle(5);
    checkOutput("afterResetDoneCount", 32'(doneCount - doneBefore), 32'd1);
    checkOutput("afterResetResult", lastResult, 32'hFF003535);

    // Second matching start during MUL is ignored
    doneBefore = doneCount;
    applyStimulus(1'b0, 1'b1, ID, 32'hFFFF0000, 32'h001F07E0, 1'b1);
    applyStimulus(1'b0, 1'b1, ID, 32'hF800F800, 32'hFFFF0000, 1'b1);
    idle(6);
    checkOutput("secondStartDoneCount", 32'(doneCount - doneBefore), 32'd1);
    checkOutput("secondStartResult", lastResult, 32'h12B6FF00);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic       rst, start, cke;
      logic [7:0] n;
      rst   = ($urandom_range(0, 59) == 0);
      start = ($urandom_range(0, 2) == 0);
      n     = ($urandom_range(0, 3) == 0) ? 8'($urandom) : ID;
      cke   = ($urandom_range(0, 4) != 0);
      applyStimulus(rst, start, n, $urandom, $urandom, cke);
    end
    idle(8);

    checkEn = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
